fifo_video_reader: RTL



---
 rtl/fifo_video_reader_if.sv | 41 ++++
 rtl/fifo_video_reader.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/fifo_video_reader_if.sv
// ---------------------------------------------------------------------------
// fifo_video_reader_if
//   Bundles the show-ahead FIFO read port and the raster video output of
//   fifo_video_reader.
//   master : the reader (consumes FIFO status/data, drives pop and video)
//   slave  : the FIFO/video sink side (drives FIFO status/data, sees video)
//   Signals:
//     fifo_dout   FIFO head word (valid whenever fifo_empty = 0)
//     fifo_empty  FIFO empty flag
//     fifo_count  FIFO occupancy
//     fifo_rd_en  pop strobe
//     vid_de      active-pixel qualifier
//     vid_hs      horizontal sync
//     vid_vs      vertical sync
//     vid_data    pixel
//     frame_start one-cycle pulse on the first pixel slot of each frame
// ---------------------------------------------------------------------------
interface fifo_video_reader_if #(
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned COUNT_WIDTH = 5
);
    logic [DATA_WIDTH-1:0]  fifo_dout;
    logic                   fifo_empty;
    logic [COUNT_WIDTH-1:0] fifo_count;
    logic                   fifo_rd_en;
    logic                   vid_de;
    logic                   vid_hs;
    logic                   vid_vs;
    logic [DATA_WIDTH-1:0]  vid_data;
    logic                   frame_start;

    modport master (
        input  fifo_dout, fifo_empty, fifo_count,
        output fifo_rd_en, vid_de, vid_hs, vid_vs, vid_data, frame_start
    );

    modport slave (
        output fifo_dout, fifo_empty, fifo_count,
        input  fifo_rd_en, vid_de, vid_hs, vid_vs, vid_data, frame_start
    );
endinterface

// File: rtl/fifo_video_reader.sv
// ---------------------------------------------------------------------------
// fifo_video_reader
//   Drains pixels from a show-ahead FIFO and regenerates a raster video
//   stream with programmable timing. A frame starts only once the FIFO holds
//   at least C_START_LEVEL words; an empty FIFO during an active pixel slot
//   outputs C_FILL and sets a sticky underflow flag.
//   Ports:
//     clk           pixel clock
//     rst           synchronous active-high reset
//     enable        run request
//     bus           FIFO read port + video output (master modport)
//     underflow     sticky underflow flag
//     underflow_clr clears underflow (a simultaneous new underflow wins)
//   Horizontal/vertical totals must not exceed 4096 (12-bit counters).
// ---------------------------------------------------------------------------
module fifo_video_reader #(
    parameter int unsigned           C_DATA_WIDTH  = 8,
    parameter int unsigned           C_COUNT_WIDTH = 5,
    parameter int unsigned           C_START_LEVEL = 8,
    parameter int unsigned           C_H_ACTIVE    = 640,
    parameter int unsigned           C_H_FP        = 16,
    parameter int unsigned           C_H_SYNC      = 96,
    parameter int unsigned           C_H_BP        = 48,
    parameter int unsigned           C_V_ACTIVE    = 480,
    parameter int unsigned           C_V_FP        = 10,
    parameter int unsigned           C_V_SYNC      = 2,
    parameter int unsigned           C_V_BP        = 33,
    parameter bit                    C_SYNC_POL    = 1'b0,
    parameter logic [C_DATA_WIDTH-1:0] C_FILL      = '0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    fifo_video_reader_if.master bus,
    output logic                underflow,
    input  logic                underflow_clr
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RUN
    } state_t;

    localparam logic [11:0] H_ACT_END  = 12'(C_H_ACTIVE);
    localparam logic [11:0] H_SYNC_BEG = 12'(C_H_ACTIVE + C_H_FP);
    localparam logic [11:0] H_SYNC_END = 12'(C_H_ACTIVE + C_H_FP + C_H_SYNC);
    localparam logic [11:0] H_LAST     = 12'(C_H_ACTIVE + C_H_FP + C_H_SYNC + C_H_BP - 1);
    localparam logic [11:0] V_ACT_END  = 12'(C_V_ACTIVE);
    localparam logic [11:0] V_SYNC_BEG = 12'(C_V_ACTIVE + C_V_FP);
    localparam logic [11:0] V_SYNC_END = 12'(C_V_ACTIVE + C_V_FP + C_V_SYNC);
    localparam logic [11:0] V_LAST     = 12'(C_V_ACTIVE + C_V_FP + C_V_SYNC + C_V_BP - 1);

    state_t state_q, state_d;
    logic [11:0] h_q, h_d;
    logic [11:0] v_q, v_d;

    logic run, act, h_act, v_act, h_sync, v_sync, last_clk, level_ok;

    logic                    rd_en;
    logic                    de_q, de_d;
    logic                    hs_q, hs_d;
    logic                    vs_q, vs_d;
    logic                    fs_q, fs_d;
    logic                    uf_q, uf_d;
    logic [C_DATA_WIDTH-1:0] data_q, data_d;

    // Counter decode
    always_comb begin
        h_act    = h_q < H_ACT_END;
        v_act    = v_q < V_ACT_END;
        h_sync   = (h_q >= H_SYNC_BEG) && (h_q < H_SYNC_END);
        v_sync   = (v_q >= V_SYNC_BEG) && (v_q < V_SYNC_END);
        act      = h_act && v_act;
        run      = state_q == ST_RUN;
        last_clk = (h_q == H_LAST) && (v_q == V_LAST);
        // Widen the count instead of narrowing the threshold so a level
        // larger than the count range can never alias to a small value.
        level_ok = 32'(bus.fifo_count) >= C_START_LEVEL;
    end

    // State and counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            h_q     <= '0;
            v_q     <= '0;
        end else begin
            state_q <= state_d;
            h_q     <= h_d;
            v_q     <= v_d;
        end
    end

    // Next state; counters only move in RUN and are held at zero elsewhere
    always_comb begin
        state_d = state_q;
        h_d     = '0;
        v_d     = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                end else if (level_ok) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (h_q == H_LAST) begin
                    h_d = '0;
                    v_d = (v_q == V_LAST) ? '0 : v_q + 12'd1;
                end else begin
                    h_d = h_q + 12'd1;
                    v_d = v_q;
                end
                // enable is only honoured at a frame boundary
                if (last_clk && !enable) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output decode: pop strobe plus next values of the registered outputs
    always_comb begin
        rd_en  = run && act && !bus.fifo_empty;
        de_d   = run && act;
        fs_d   = run && (h_q == '0) && (v_q == '0);
        hs_d   = (run && h_sync) ? C_SYNC_POL : ~C_SYNC_POL;
        vs_d   = (run && v_sync) ? C_SYNC_POL : ~C_SYNC_POL;
        data_d = '0;
        if (run && act) begin
            data_d = bus.fifo_empty ? C_FILL : bus.fifo_dout;
        end
        uf_d = uf_q;
        if (underflow_clr) begin
            uf_d = 1'b0;
        end
        if (run && act && bus.fifo_empty) begin
            uf_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            de_q   <= 1'b0;
            hs_q   <= ~C_SYNC_POL;
            vs_q   <= ~C_SYNC_POL;
            fs_q   <= 1'b0;
            uf_q   <= 1'b0;
            data_q <= '0;
        end else begin
            de_q   <= de_d;
            hs_q   <= hs_d;
            vs_q   <= vs_d;
            fs_q   <= fs_d;
            uf_q   <= uf_d;
            data_q <= data_d;
        end
    end

    assign bus.fifo_rd_en  = rd_en;
    assign bus.vid_de      = de_q;
    assign bus.vid_hs      = hs_q;
    assign bus.vid_vs      = vs_q;
    assign bus.vid_data    = data_q;
    assign bus.frame_start = fs_q;
    assign underflow       = uf_q;

endmodule
